fpu_rr_arbiter: RTL
===================

Name: fpu_rr_arbiter

Overview:
- Shares one fixed-latency FP dot-product datapath (computes I1*I2 + I3*I4) among NUM_REQ requesters.
- Arbitration is round-robin.
- Issues at most one operand set per cycle and tracks in-flight operations with a tag pipeline.
- Routes each result back to the requester that issued it.
- Sits between the byte-serial I/O front-ends and the FPU datapath, replacing direct operand-register loading.
- Provides a drain/halt mode so software can quiesce the datapath.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- LATENCY, 2: datapath cycles from dp_issue high to dp_result valid (>=1).
- OP_W, 32: operand/result width (IEEE-754 single).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester k has an operand set pending.
- req_ready  out  NUM_REQ  grant; transfer when req_valid[k] & req_ready[k].
- req_ops  in  NUM_REQ*4*OP_W  requester k occupies [k*4*OP_W +: 4*OP_W]; I1 is the lowest OP_W, then I2, I3, I4.
- drain  in  1  stop granting and empty the pipeline.
- drain_done  out  1  high while halted with the pipeline empty.
- dp_i1, dp_i2, dp_i3, dp_i4  out  OP_W each  operands to the datapath (registered).
- dp_issue  out  1  operands valid this cycle (registered).
- dp_result  in  OP_W  datapath result, valid LATENCY cycles after dp_issue.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the owning requester.
- rsp_data  out  OP_W  result (registered).
- busy  out  1  dp_issue or any tag-pipeline stage valid.
- stat_count  out  16*NUM_REQ  per-requester issue counts (see Optional Feature).

Behaviour:
- Reset values:
  - req_ready=0, dp_i1..dp_i4=0, dp_issue=0, rsp_valid=0, rsp_data=0, drain_done=0, stat_count=0.
  - Tag pipeline all invalid; round-robin pointer=0; FSM=RUN.
- FSM states:
  - RUN: arbitration enabled. If drain=1 → DRAIN.
  - DRAIN: no grants. When busy=0 → HALT.
  - HALT: drain_done=1, no grants. When drain=0 → RUN; drain_done drops the same edge.
- Arbitration (RUN only, combinational req_ready):
  - Search req_valid starting at the pointer index, wrapping modulo NUM_REQ; the first set bit wins.
  - At most one req_ready bit high; req_ready=0 when no request.
  - drain=1 in RUN masks grants in that same cycle.
  - On a grant to k: pointer <= (k+1) mod NUM_REQ. No grant leaves the pointer unchanged.
- Issue:
  - A grant in cycle T causes dp_i1..dp_i4 <= winner's operands and dp_issue=1 in T+1.
  - With no grant, dp_issue=0 and dp_i* hold their last value.
  - Throughput is one issue per cycle; back-to-back grants to the same requester are allowed only if no other requester is valid.
- Tag pipeline:
  - LATENCY stages of {valid, index}, entered together with dp_issue and shifted every cycle.
  - The final stage aligns with dp_result. Then rsp_data <= dp_result and rsp_valid <= onehot(index) when valid, else rsp_valid <= 0.
  - Grant-to-response latency is LATENCY+2 cycles: grant at T, rsp_valid at T+LATENCY+2.
- rsp_data holds its last value when rsp_valid=0.
- The arbiter does no arithmetic on data; operands and results pass through bit-exact.
- Boundaries:
  - Simultaneous drain and grant-eligible requests: drain wins, no grant.
  - drain deasserted while in DRAIN: stay in DRAIN until busy=0, then go directly to RUN (skip HALT).
  - Async reset mid-operation: all in-flight tags discarded, no rsp_valid emitted for them.
  - Requester dropping req_valid without a handshake is legal; no state change.

Optional Feature:
- Macro FPU_ARB_STATS_EN.
- Defined: 16-bit saturating counter per requester, incremented on each handshake, stops at 0xFFFF, cleared only by reset. stat_count[k*16 +: 16] drives counter k.
- Undefined: counters not built, stat_count tied to 0.

Test Plan:
- Single op: req_valid=01, ops I1=0x3F800000, I2=0x40000000, I3=0x40400000, I4=0x40800000, model datapath LATENCY=2 returning 0x41600000 → dp_issue at T+1 with those operands; rsp_valid=01, rsp_data=0x41600000 at T+4.
- Contention: req_valid=11 held for 4 cycles → grants alternate 01,10,01,10 (pointer starts 0); four responses in the same order, tags correct.
- Back-to-back single requester: req_valid=10 for 5 cycles → 5 consecutive dp_issue, 5 consecutive rsp_valid=10, busy high throughout.
- Drain: assert drain with 2 ops in flight → no grant that cycle, both responses still delivered, drain_done=1 one cycle after busy=0; release drain → grants resume next cycle.
- Reset mid-flight: drop rst_n while 2 tags valid → all outputs 0 immediately, no rsp_valid after release, pointer=0.
- Stats (FPU_ARB_STATS_EN): 3 grants to requester 0, 1 to requester 1 → stat_count = {16'd1, 16'd3}; forced saturation value 0xFFFF holds on the next grant.

Source files
------------

// File: rtl/fpu_rr_arbiter_if.sv
// fpu_rr_arbiter_if: requester-side bus of the FPU arbiter.
// Carries the per-requester operand handshake and the routed result pulse.
interface fpu_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*4*OP_W-1:0] req_ops;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [OP_W-1:0]           rsp_data;

  // Requester side: offers operand sets, receives grants and results
  modport master (
    output req_valid, req_ops,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_ops,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin sharing of one fixed-latency FP dot-product
// datapath (I1*I2 + I3*I4) among NUM_REQ requesters, with a tag pipeline that
// routes each result back to its issuer and a drain/halt mode for quiescing.
// Optional feature: define FPU_ARB_STATS_EN to build per-requester 16-bit
// saturating issue counters on stat_count; otherwise stat_count reads 0.
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int OP_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fpu_rr_arbiter_if.slave         req_bus,
  input  logic                    drain,
  output logic                    drain_done,
  output logic [OP_W-1:0]         dp_i1,
  output logic [OP_W-1:0]         dp_i2,
  output logic [OP_W-1:0]         dp_i3,
  output logic [OP_W-1:0]         dp_i4,
  output logic                    dp_issue,
  input  logic [OP_W-1:0]         dp_result,
  output logic                    busy,
  output logic [16*NUM_REQ-1:0]   stat_count
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int SET_W = 4 * OP_W;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_vec;
  logic               arb_en;
  logic [SET_W-1:0]   win_ops;
  logic [IDX_W-1:0]   issue_idx;
  logic [LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]   tag_idx [LATENCY];

  // Grants only in RUN; a drain request suppresses the grant in the same cycle
  assign arb_en = (state == ST_RUN) && !drain;

  // Round-robin search from the pointer, wrapping; first valid requester wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    grant_vec = '0;
    if (arb_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
        if (!grant_any && req_bus.req_valid[cand_idx]) begin
          grant_any = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
    grant_vec[grant_idx] = grant_any;
  end

  // Grants are forced low while reset is held so the bus reads idle immediately
  assign req_bus.req_ready = grant_vec & {NUM_REQ{rst_n}};
  assign win_ops           = req_bus.req_ops[int'(grant_idx)*SET_W +: SET_W];

  // Issue register: capture the winner's operands and advance the pointer past it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      dp_issue  <= 1'b0;
      issue_idx <= '0;
      dp_i1     <= '0;
      dp_i2     <= '0;
      dp_i3     <= '0;
      dp_i4     <= '0;
    end else begin
      dp_issue <= grant_any;
      if (grant_any) begin
        ptr       <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        issue_idx <= grant_idx;
        dp_i1     <= win_ops[0*OP_W +: OP_W];
        dp_i2     <= win_ops[1*OP_W +: OP_W];
        dp_i3     <= win_ops[2*OP_W +: OP_W];
        dp_i4     <= win_ops[3*OP_W +: OP_W];
      end
    end
  end

  // Tag pipeline follows dp_issue so its last stage lines up with dp_result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_valid[0] <= dp_issue;
      tag_idx[0]   <= issue_idx;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  // Route the aligned result to its owner; data holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_bus.rsp_valid <= '0;
      req_bus.rsp_data  <= '0;
    end else if (tag_valid[LATENCY-1]) begin
      req_bus.rsp_valid <= NUM_REQ'(1) << tag_idx[LATENCY-1];
      req_bus.rsp_data  <= dp_result;
    end else begin
      req_bus.rsp_valid <= '0;
    end
  end

  assign busy = dp_issue | (|tag_valid);

  // Drain sequencing; releasing drain before the pipe empties skips HALT
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (drain) state_next = ST_DRAIN;
      ST_DRAIN: if (!busy) state_next = drain ? ST_HALT : ST_RUN;
      ST_HALT:  if (!drain) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  assign drain_done = (state == ST_HALT);

`ifdef FPU_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [15:0] cnt;
    // Saturating per-requester handshake counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (req_bus.req_valid[gi] && req_bus.req_ready[gi] && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
    assign stat_count[gi*16 +: 16] = cnt;
  end
`else
  assign stat_count = '0;
`endif
endmodule
